// File: rtl/freq_gen.sv
// Programmable square-wave generator: half-period H = CLK_HZ/(2*freq) found by a serial divider.
// Optional macro FREQ_GEN_EDGE_CNT_EN adds a 32-bit count of sig_out rising edges.
module freq_gen #(
  parameter int unsigned CLK_HZ = 200_000_000,
  parameter int unsigned F_MIN  = 10,
  parameter int unsigned F_MAX  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        ld,
  input  logic [31:0] freq_in,
  output logic        sig_out,
  output logic        busy,
`ifdef FREQ_GEN_EDGE_CNT_EN
  output logic [31:0] edge_cnt,
`endif
  output logic        err
);

  localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);
  localparam logic [31:0] FMIN_W   = 32'(F_MIN);
  localparam logic [31:0] FMAX_W   = 32'(F_MAX);

  typedef enum logic [1:0] {IDLE, DIV, RUN} state_t;

  state_t      state_q, state_d;
  logic        sig_q, sig_d;
  logic        err_q, err_d;
  logic [31:0] freq_q, freq_d;
  logic [23:0] h_q, h_d;
  logic [23:0] phase_q, phase_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [4:0]  iter_q, iter_d;

  logic        ld_ok;
  logic        in_range;
  logic [33:0] rem_shift;
  logic [33:0] divisor;
  logic [32:0] rem_sub;
  logic        rem_ge;

`ifdef FREQ_GEN_EDGE_CNT_EN
  logic [31:0] edge_cnt_q, edge_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    err_d   = err_q;
    freq_d  = freq_q;
    h_d     = h_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    iter_d  = iter_q;

    ld_ok    = ld && (state_q != DIV);
    in_range = (freq_in >= FMIN_W) && (freq_in <= FMAX_W);

    // Dividend bits are shifted out of the top of quo_q while quotient bits enter at the bottom.
    rem_shift = {rem_q, quo_q[31]};
    divisor   = {1'b0, freq_q, 1'b0};
    rem_ge    = rem_shift >= divisor;
    rem_sub   = rem_shift[32:0] - divisor[32:0];

    case (state_q)
      DIV: begin
        rem_d  = rem_ge ? rem_sub : rem_shift[32:0];
        quo_d  = {quo_q[30:0], rem_ge};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          state_d = RUN;
          h_d     = quo_d[23:0];
          phase_d = '0;
          sig_d   = 1'b0;
        end
      end
      RUN: begin
        if (en) begin
          if (phase_q == h_q - 24'd1) begin
            phase_d = '0;
            sig_d   = ~sig_q;
          end else begin
            phase_d = phase_q + 24'd1;
          end
        end else begin
          phase_d = '0;
          sig_d   = 1'b0;
        end
      end
      default: ;
    endcase

    // A load overrides the RUN update, including a coincident toggle.
    if (ld_ok) begin
      if (in_range) begin
        err_d   = 1'b0;
        freq_d  = freq_in;
        state_d = DIV;
        sig_d   = 1'b0;
        phase_d = '0;
        rem_d   = '0;
        quo_d   = DIVIDEND;
        iter_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end

`ifdef FREQ_GEN_EDGE_CNT_EN
    edge_cnt_d = edge_cnt_q + {31'd0, (sig_d & ~sig_q)};
    if (ld_ok && in_range) edge_cnt_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= 1'b0;
      err_q   <= 1'b0;
      freq_q  <= '0;
      h_q     <= '0;
      phase_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
      freq_q  <= freq_d;
      h_q     <= h_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      iter_q  <= iter_d;
    end
  end

`ifdef FREQ_GEN_EDGE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) edge_cnt_q <= '0;
    else     edge_cnt_q <= edge_cnt_d;
  end
  assign edge_cnt = edge_cnt_q;
`endif

  assign sig_out = sig_q;
  assign busy    = (state_q == DIV);
  assign err     = err_q;

endmodule
